// File: rtl/c2hdl_bus_pkg.sv
// c2hdl_bus_pkg: shared FSM states, access-size codes and abort read data for the bus arbiter
package c2hdl_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ACK,
        ST_HOLD
    } state_e;

    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;

    localparam logic [31:0] DEF_ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/c2hdl_bus_arbiter_rr_pick.sv
// c2hdl_rr_pick: combinational round-robin picker, search starts one past the last grant and wraps
module c2hdl_rr_pick import c2hdl_bus_pkg::*; #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic          any_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] c;

    // walk from the lowest to the highest priority offset so the nearest requester after last wins
    always_comb begin
        any_o = |req_i;
        idx_o = '0;
        c     = '0;
        for (int k = N; k >= 1; k--) begin
            c = IW'((int'(last_i) + k) % N);
            if (req_i[c]) idx_o = c;
        end
    end

endmodule

// File: rtl/c2hdl_bus_arbiter.sv
// c2hdl_bus_arbiter: round-robin share of one pulse-acknowledged memory port among N c2hdl cores
module c2hdl_bus_arbiter import c2hdl_bus_pkg::*; #(
    parameter int             N         = 2,
    parameter int             DW        = 32,
    parameter int             TIMEOUT   = 255,
    parameter logic [DW-1:0]  ERR_RDATA = DW'(DEF_ERR_RDATA)
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [N*DW-1:0]       req_addr_i,
    input  logic [N*3-1:0]        req_size_i,
    input  logic [N-1:0]          req_valid_i,
    input  logic [N-1:0]          req_write_i,
    input  logic [N*DW-1:0]       req_wdata_i,
    output logic [N-1:0]          req_ready_o,
    output logic [DW-1:0]         req_rdata_o,
    output logic [DW-1:0]         mem_addr_o,
    output logic [2:0]            mem_size_o,
    output logic                  mem_write_o,
    output logic [DW-1:0]         mem_wdata_o,
    output logic                  mem_valid_o,
    input  logic [DW-1:0]         mem_rdata_i,
    input  logic                  mem_ready_i,
    output logic [$clog2(N)-1:0]  gnt_id_o,
    output logic                  busy_o,
    output logic                  err_o,
    output logic [$clog2(N)-1:0]  err_id_o,
    input  logic                  err_clr_i
);

    localparam int             IW = $clog2(N);
    localparam logic [15:0]    TO = 16'(TIMEOUT);

    state_e          state_q, state_d;
    logic [DW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [2:0]      size_q, size_d;
    logic            write_q, write_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic [N-1:0]    ready_q, ready_d;
    logic [N-1:0]    gnt_oh;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   err_id_q, err_id_d;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [15:0]     cnt_q, cnt_d;
    logic            tmo;

    c2hdl_rr_pick #(.N(N)) u_pick (
        .req_i  (req_valid_i),
        .last_i (last_q),
        .any_o  (pick_any),
        .idx_o  (pick_idx)
    );

    assign gnt_oh = N'(1) << gnt_q;

    // next-state: grant in IDLE, wait for the memory pulse or the timeout in ISSUE, shape ready in ACK/HOLD
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        valid_d  = valid_q;
        rdata_d  = rdata_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        ready_d  = '0;
        tmo      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_ISSUE;
                    addr_d  = req_addr_i[int'(pick_idx)*DW +: DW];
                    size_d  = req_size_i[int'(pick_idx)*3 +: 3];
                    write_d = req_write_i[pick_idx];
                    wdata_d = req_wdata_i[int'(pick_idx)*DW +: DW];
                    valid_d = 1'b1;
                    gnt_d   = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_ISSUE: begin
                if (mem_ready_i) begin
                    state_d = ST_ACK;
                    valid_d = 1'b0;
                    ready_d = gnt_oh;
                    rdata_d = write_q ? rdata_q : mem_rdata_i;
                end else if (cnt_q + 16'd1 == TO) begin
                    state_d = ST_ACK;
                    valid_d = 1'b0;
                    ready_d = gnt_oh;
                    rdata_d = write_q ? rdata_q : ERR_RDATA;
                    tmo     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_ACK: begin
                state_d = write_q ? ST_IDLE : ST_HOLD;
                ready_d = write_q ? '0 : gnt_oh;
            end
            ST_HOLD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        err_d    = tmo | (err_q & ~err_clr_i);
        err_id_d = (tmo && (!err_q || err_clr_i)) ? gnt_q : err_id_q;
        busy_d   = state_d != ST_IDLE;
    end

    // state and output registers; reset drops everything back to an idle, error-free port
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            valid_q  <= 1'b0;
            rdata_q  <= '0;
            ready_q  <= '0;
            gnt_q    <= '0;
            last_q   <= IW'(N - 1);
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            err_id_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            valid_q  <= valid_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            err_id_q <= err_id_d;
        end
    end

    assign req_ready_o = ready_q;
    assign req_rdata_o = rdata_q;
    assign mem_addr_o  = addr_q;
    assign mem_size_o  = size_q;
    assign mem_write_o = write_q;
    assign mem_wdata_o = wdata_q;
    assign mem_valid_o = valid_q;
    assign gnt_id_o    = gnt_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;
    assign err_id_o    = err_id_q;

endmodule

// File: tb/tb_c2hdl_bus_arbiter.sv
// tb_c2hdl_bus_arbiter: directed vectors, timeout/reset/contention sequences and a randomized two-core run
module tb_c2hdl_bus_arbiter;
    import c2hdl_bus_pkg::*;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int TARGET = 20;

    logic              clk = 1'b0;
    logic              rstb = 1'b0;
    logic [N*DW-1:0]   req_addr = '0;
    logic [N*3-1:0]    req_size = '0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_write = '0;
    logic [N*DW-1:0]   req_wdata = '0;
    logic [N-1:0]      req_ready;
    logic [DW-1:0]     req_rdata;
    logic [DW-1:0]     mem_addr;
    logic [2:0]        mem_size;
    logic              mem_write;
    logic [DW-1:0]     mem_wdata;
    logic              mem_valid;
    logic [DW-1:0]     mem_rdata = '0;
    logic              mem_ready = 1'b0;
    logic [0:0]        gnt_id;
    logic              busy;
    logic              err;
    logic [0:0]        err_id;
    logic              err_clr = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    c2hdl_bus_arbiter #(.N(N), .DW(DW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rstb        (rstb),
        .req_addr_i  (req_addr),
        .req_size_i  (req_size),
        .req_valid_i (req_valid),
        .req_write_i (req_write),
        .req_wdata_i (req_wdata),
        .req_ready_o (req_ready),
        .req_rdata_o (req_rdata),
        .mem_addr_o  (mem_addr),
        .mem_size_o  (mem_size),
        .mem_write_o (mem_write),
        .mem_wdata_o (mem_wdata),
        .mem_valid_o (mem_valid),
        .mem_rdata_i (mem_rdata),
        .mem_ready_i (mem_ready),
        .gnt_id_o    (gnt_id),
        .busy_o      (busy),
        .err_o       (err),
        .err_id_o    (err_id),
        .err_clr_i   (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          core;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] mrd;
        int          lat;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit c, input bit wr, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        req_addr[int'(c)*DW +: DW]  = a;
        req_size[int'(c)*3 +: 3]    = s;
        req_wdata[int'(c)*DW +: DW] = d;
        req_write[c]                = wr;
        req_valid[c]                = 1'b1;
    endtask

    task automatic check_reset(input string t);
        chk({t, " mem_valid"}, mem_valid, 0);
        chk({t, " mem_addr"},  mem_addr, 0);
        chk({t, " mem_size"},  mem_size, 0);
        chk({t, " mem_write"}, mem_write, 0);
        chk({t, " mem_wdata"}, mem_wdata, 0);
        chk({t, " req_ready"}, req_ready, 0);
        chk({t, " req_rdata"}, req_rdata, 0);
        chk({t, " gnt_id"},    gnt_id, 0);
        chk({t, " busy"},      busy, 0);
        chk({t, " err"},       err, 0);
        chk({t, " err_id"},    err_id, 0);
    endtask

    task automatic run_vec(input vec_t v);
        set_req(v.core, v.wr, v.addr, v.size, v.wdata);
        tick;
        chk("vec mem_valid rise", mem_valid, 1);
        chk("vec mem_addr", mem_addr, v.addr);
        chk("vec mem_write", mem_write, v.wr);
        chk("vec mem_size", mem_size, v.size);
        chk("vec mem_wdata", mem_wdata, v.wdata);
        chk("vec gnt_id", gnt_id, v.core);
        chk("vec busy", busy, 1);
        chk("vec ready early", req_ready, 0);
        for (int w = 0; w < v.lat; w++) begin
            tick;
            chk("vec mem_valid wait", mem_valid, 1);
            chk("vec ready wait", req_ready, 0);
        end
        mem_ready = 1'b1;
        mem_rdata = v.mrd;
        tick;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        chk("vec ack ready", req_ready, 2'b01 << v.core);
        chk("vec ack mem_valid", mem_valid, 0);
        chk("vec ack rdata", req_rdata, v.exp_rd);
        req_valid[v.core] = 1'b0;
        tick;
        if (!v.wr) begin
            chk("vec hold ready", req_ready, 2'b01 << v.core);
            chk("vec hold rdata", req_rdata, v.exp_rd);
            chk("vec hold mem_valid", mem_valid, 0);
            tick;
        end
        chk("vec end ready", req_ready, 0);
        chk("vec end busy", busy, 0);
        chk("vec end mem_valid", mem_valid, 0);
        chk("vec end rdata", req_rdata, v.exp_rd);
    endtask

    task automatic tmo_txn(input bit c, input bit wr, input bit clr_last, input logic [31:0] exp_rd, input logic [0:0] exp_id);
        int n;
        n = 0;
        set_req(c, wr, 32'h80 + 32'(c) * 4, SIZE_W, 32'h5555_0000 + 32'(c));
        for (int i = 0; i < 20; i++) begin
            tick;
            if (!mem_valid) break;
            n++;
            err_clr = clr_last && (n == TO);
        end
        err_clr = 1'b0;
        chk("tmo issue cycles", n, TO);
        chk("tmo ready", req_ready, 2'b01 << c);
        chk("tmo rdata", req_rdata, exp_rd);
        chk("tmo err", err, 1);
        chk("tmo err_id", err_id, exp_id);
        req_valid[c] = 1'b0;
        tick;
        if (!wr) begin
            chk("tmo hold ready", req_ready, 2'b01 << c);
            tick;
        end
        chk("tmo end busy", busy, 0);
    endtask

    function automatic int rr(input logic [1:0] v, input int l);
        for (int k = 1; k <= N; k++)
            if (((v >> ((l + k) % N)) & 2'b01) != 0) return (l + k) % N;
        return -1;
    endfunction

    logic [31:0] ref_mem[16];
    logic [31:0] c_addr[2];
    logic [31:0] c_wd[2];
    bit          c_wr[2];
    bit          pending[2];
    int          started[2];
    int          done[2];
    int          rl[2];

    initial begin
        int g, last, e, mwait, issues, total_done;
        bit prev_mv;
        logic [1:0] prev_drv, prev_rdy, rdy;
        logic [31:0] last_rd, exp;
        vecs[0] = '{1'b0, 1'b1, 32'h100, SIZE_W, 32'hA5A5A5A5, 32'h0,        1, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h40,  SIZE_W, 32'h0,        32'h12345678, 0, 32'h12345678};
        vecs[2] = '{1'b1, 1'b1, 32'h44,  SIZE_W, 32'h11112222, 32'h99999999, 2, 32'h12345678};
        vecs[3] = '{1'b0, 1'b0, 32'h8,   SIZE_B, 32'h0,        32'h000000AB, 3, 32'h000000AB};
        vecs[4] = '{1'b0, 1'b0, 32'hA,   SIZE_H, 32'h0,        32'hCAFE0000, 0, 32'hCAFE0000};
        vecs[5] = '{1'b1, 1'b1, 32'h3,   SIZE_B, 32'h77000000, 32'h0BAD0BAD, 0, 32'hCAFE0000};

        tick;
        check_reset("reset");
        @(negedge clk);
        rstb = 1'b1;
        tick;
        check_reset("post-reset idle");

        for (int i = 0; i < 6; i++) run_vec(vecs[3'(i)]);

        tmo_txn(1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1);
        tmo_txn(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
        tmo_txn(1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("err_clr err", err, 0);
        chk("err_clr err_id kept", err_id, 0);
        tick;
        chk("err stays clear", err, 0);

        set_req(1'b1, 1'b0, 32'h20, SIZE_W, 32'h0);
        tick;
        tick;
        chk("pre-reset mem_valid", mem_valid, 1);
        #2;
        rstb = 1'b0;
        #1;
        check_reset("async reset");
        set_req(1'b0, 1'b1, 32'h200, SIZE_W, 32'h0000_0A0A);
        set_req(1'b1, 1'b1, 32'h300, SIZE_W, 32'h0000_0B0B);
        @(negedge clk);
        rstb = 1'b1;
        g = 0;
        prev_mv = 1'b0;
        for (int i = 0; i < 60 && g < 8; i++) begin
            tick;
            if (mem_valid && !prev_mv) begin
                chk("contention gnt", gnt_id, g % 2);
                chk("contention addr", mem_addr, (g % 2) != 0 ? 32'h300 : 32'h200);
                g++;
            end
            prev_mv = mem_valid;
            mem_ready = mem_valid;
        end
        mem_ready = 1'b0;
        chk("contention grants", g, 8);
        req_valid = '0;

        rstb = 1'b0;
        tick;
        @(negedge clk);
        rstb = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[4'(i)] = $urandom;
        for (int i = 0; i < 2; i++) begin
            pending[1'(i)] = 1'b0;
            started[1'(i)] = 0;
            done[1'(i)] = 0;
            rl[1'(i)] = 0;
        end
        last = N - 1;
        mwait = 0;
        issues = 0;
        prev_mv = 1'b0;
        prev_drv = '0;
        prev_rdy = '0;
        last_rd = 32'h0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick;
            rdy = req_ready;
            chk("rand ready onehot0", $onehot0(rdy), 1);
            if (mem_valid && !prev_mv) begin
                e = rr(prev_drv, last);
                chk("rand gnt", gnt_id, e);
                chk("rand mem_addr", mem_addr, c_addr[1'(e)]);
                chk("rand mem_write", mem_write, c_wr[1'(e)]);
                chk("rand mem_size", mem_size, SIZE_W);
                if (c_wr[1'(e)]) chk("rand mem_wdata", mem_wdata, c_wd[1'(e)]);
                last = e;
                issues++;
                mwait = $urandom_range(0, 3);
            end
            for (int i = 0; i < 2; i++) begin
                bit ci;
                ci = i[0];
                rl[ci] = rdy[ci] ? rl[ci] + 1 : 0;
                if (rdy[ci] && !prev_rdy[ci]) begin
                    chk("rand done gnt", gnt_id, ci);
                    chk("rand done pending", pending[ci], 1);
                    if (!c_wr[ci]) begin
                        exp = ref_mem[c_addr[ci][5:2]];
                        chk("rand load rdata", req_rdata, exp);
                        last_rd = exp;
                    end else begin
                        chk("rand store rdata kept", req_rdata, last_rd);
                    end
                    pending[ci] = 1'b0;
                    done[ci]++;
                end else if (rdy[ci]) begin
                    chk("rand hold is load", c_wr[ci], 0);
                    chk("rand hold rdata", req_rdata, last_rd);
                    chk("rand hold length", rl[ci] <= 2, 1);
                end
            end
            if (mem_valid) begin
                if (mwait == 0) begin
                    mem_ready = 1'b1;
                    if (mem_write) begin
                        ref_mem[mem_addr[5:2]] = mem_wdata;
                        mem_rdata = $urandom;
                    end else begin
                        mem_rdata = ref_mem[mem_addr[5:2]];
                    end
                end else begin
                    mem_ready = 1'b0;
                    mwait--;
                    mem_rdata = $urandom;
                end
            end else begin
                mem_ready = ($urandom_range(0, 2) == 0);
                mem_rdata = $urandom;
            end
            for (int i = 0; i < 2; i++) begin
                bit ci;
                ci = i[0];
                if (!pending[ci] && !rdy[ci] && started[ci] < TARGET && $urandom_range(0, 3) != 0) begin
                    c_addr[ci] = 32'($urandom_range(0, 15)) << 2;
                    c_wr[ci] = 1'($urandom_range(0, 1));
                    c_wd[ci] = $urandom;
                    set_req(ci, c_wr[ci], c_addr[ci], SIZE_W, c_wd[ci]);
                    pending[ci] = 1'b1;
                    started[ci]++;
                end
                req_valid[ci] = pending[ci];
            end
            prev_drv = req_valid;
            prev_rdy = rdy;
            prev_mv = mem_valid;
            if (done[0] == TARGET && done[1] == TARGET && !busy) break;
        end
        mem_ready = 1'b0;
        req_valid = '0;
        total_done = done[0] + done[1];
        chk("rand all completed", total_done, 2 * TARGET);
        chk("rand one issue per txn", issues, total_done);
        chk("rand no error", err, 0);
        chk("rand idle at end", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
